// File: rtl/regfile_dumper_pkg.sv
// Shared definitions for the register-file dump engine: state encodings and
// the default register-file geometry shared with the register file itself.
package regfile_dumper_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/regfile_dumper.sv
// Walks registers FIRST_REG..LAST_REG through one register-file read port and
// streams each one as an {addr, data} beat, stalling the CPU while it runs.
module regfile_dumper
    import regfile_dumper_pkg::*;
#(
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int DATA_W    = RF_DATA_W,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [DATA_W-1:0] rf_rd,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            dump_addr_q <= '0;
            dump_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            dump_addr_q <= dump_addr_d;
            dump_data_q <= dump_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = FIRST_A;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // Read port is combinational, so the word is captured this edge.
                dump_addr_d = addr_q;
                dump_data_d = rf_rd;
                state_d     = abort ? ST_IDLE : ST_SEND;
            end
            ST_SEND: begin
                // Abort wins even when it coincides with the handshake.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (dump_ready) begin
                    if (addr_q == LAST_A) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
        endcase
    end

    // addr_q only moves on entry to READ, so it doubles as the held read address.
    assign rf_ra      = addr_q;
    assign busy       = (state_q == ST_READ) || (state_q == ST_SEND);
    assign cpu_stall  = busy;
    assign done       = (state_q == ST_DONE);
    assign dump_valid = (state_q == ST_SEND);
    assign dump_addr  = dump_addr_q;
    assign dump_data  = dump_data_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops on
// every handshake. Instance a dumps 0..31, instance b dumps 4..6.
module tb_regfile_dumper;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start_a, abort_a, busy_a, done_a, cpu_stall_a, dump_valid_a, dump_ready_a;
    logic [4:0]  rf_ra_a, dump_addr_a;
    logic [31:0] rf_rd_a, dump_data_a;
    logic        start_b, abort_b, busy_b, done_b, cpu_stall_b, dump_valid_b, dump_ready_b;
    logic [4:0]  rf_ra_b, dump_addr_b;
    logic [31:0] rf_rd_b, dump_data_b;

    logic [31:0] rf [32];
    assign rf_rd_a = (rf_ra_a == 5'd0) ? 32'd0 : rf[rf_ra_a];
    assign rf_rd_b = (rf_ra_b == 5'd0) ? 32'd0 : rf[rf_ra_b];

    regfile_dumper u_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .cpu_stall(cpu_stall_a),
        .rf_ra(rf_ra_a), .rf_rd(rf_rd_a),
        .dump_valid(dump_valid_a), .dump_ready(dump_ready_a),
        .dump_addr(dump_addr_a), .dump_data(dump_data_a)
    );

    regfile_dumper #(.FIRST_REG(4), .LAST_REG(6)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .cpu_stall(cpu_stall_b),
        .rf_ra(rf_ra_b), .rf_rd(rf_rd_b),
        .dump_valid(dump_valid_b), .dump_ready(dump_ready_b),
        .dump_addr(dump_addr_b), .dump_data(dump_data_b)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    logic [36:0] qa[$];
    logic [36:0] qb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [36:0] exp_beat(input int i);
        logic [31:0] d;
        d = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
        return {5'(i), d};
    endfunction

    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (dump_valid_a && dump_ready_a) begin
            chk("a_beat_expected", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) chk("a_beat", 64'({dump_addr_a, dump_data_a}), 64'(qa.pop_front()));
        end
        if (dump_valid_b && dump_ready_b) begin
            chk("b_beat_expected", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) chk("b_beat", 64'({dump_addr_b, dump_data_b}), 64'(qb.pop_front()));
        end
    end

    task automatic check_reset_a(input string tag);
        chk({tag, "_busy"},      64'(busy_a),       64'd0);
        chk({tag, "_stall"},     64'(cpu_stall_a),  64'd0);
        chk({tag, "_done"},      64'(done_a),       64'd0);
        chk({tag, "_valid"},     64'(dump_valid_a), 64'd0);
        chk({tag, "_dump_addr"}, 64'(dump_addr_a),  64'd0);
        chk({tag, "_dump_data"}, 64'(dump_data_a),  64'd0);
        chk({tag, "_rf_ra"},     64'(rf_ra_a),      64'd0);
    endtask

    // One dump on instance a. Negative *_at values disable that event.
    task automatic dump_a(input string tag, input int n_exp, input int stall_at,
                          input int abort_at, input int restart_at, input int reset_at,
                          input int exp_cycles, input bit exp_done);
        int c;
        int s = 0;
        bit stalled = 0;
        bit restarted = 0;
        int dc0 = done_cnt_a;
        logic [36:0] sb;
        for (int i = 0; i < n_exp; i++) qa.push_back(exp_beat(i));
        @(posedge clk); #1 start_a = 1'b1; dump_ready_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        chk({tag, "_stall_first_read"}, 64'(cpu_stall_a), 64'd1);
        chk({tag, "_rf_ra_first_read"}, 64'(rf_ra_a), 64'd0);
        chk({tag, "_valid_first_read"}, 64'(dump_valid_a), 64'd0);
        for (c = 1; c < 400; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            start_a = 1'b0; abort_a = 1'b0; reset = 1'b0;
            if (done_a || !busy_a) break;
            if (c == 2) chk({tag, "_valid_latency"}, 64'(dump_valid_a), 64'd1);
            if (stalled && s < 5) begin
                sb = exp_beat(stall_at);
                chk({tag, "_stall_valid"}, 64'(dump_valid_a), 64'd1);
                chk({tag, "_stall_addr_data"}, 64'({dump_addr_a, dump_data_a}), 64'(sb));
                s++;
                if (s == 5) dump_ready_a = 1'b1;
            end else if (!stalled && stall_at >= 0 && dump_valid_a && dump_addr_a == 5'(stall_at)) begin
                stalled = 1'b1;
                dump_ready_a = 1'b0;
            end
            if (abort_at >= 0 && dump_valid_a && dump_addr_a == 5'(abort_at)) begin
                dump_ready_a = 1'b0;
                abort_a = 1'b1;
            end
            if (reset_at >= 0 && dump_valid_a && dump_addr_a == 5'(reset_at)) begin
                dump_ready_a = 1'b0;
                reset = 1'b1;
            end
            if (restart_at >= 0 && !restarted && dump_valid_a && dump_addr_a == 5'(restart_at)) begin
                start_a = 1'b1;
                restarted = 1'b1;
            end
        end
        chk({tag, "_end_cycle"}, 64'(c), 64'(exp_cycles));
        chk({tag, "_done_at_end"}, 64'(done_a), 64'(exp_done));
        chk({tag, "_busy_at_end"}, 64'(busy_a), 64'd0);
        chk({tag, "_valid_at_end"}, 64'(dump_valid_a), 64'd0);
        if (reset_at >= 0) check_reset_a({tag, "_rst"});
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_done_count"}, 64'(done_cnt_a - dc0), 64'(exp_done));
        chk({tag, "_queue_drained"}, 64'(qa.size()), 64'd0);
        chk({tag, "_idle_after"}, 64'(busy_a), 64'd0);
    endtask

    initial begin
        int c;
        for (int i = 1; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        rf[0] = 32'hFFFF_FFFF;  // the port hardwires r0, this must never appear
        reset = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; dump_ready_a = 1'b1;
        start_b = 1'b0; abort_b = 1'b0; dump_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_a("reset_a");
        chk("reset_b_busy",  64'(busy_b), 64'd0);
        chk("reset_b_stall", 64'(cpu_stall_b), 64'd0);
        chk("reset_b_valid", 64'(dump_valid_b), 64'd0);
        chk("reset_b_rf_ra", 64'(rf_ra_b), 64'd0);
        reset = 1'b0;

        dump_a("full",    32, -1, -1, -1, -1, 65, 1'b1);
        dump_a("stall7",  32,  7, -1, -1, -1, 70, 1'b1);
        dump_a("abort10", 10, -1, 10, -1, -1, 23, 1'b0);
        dump_a("restart", 32, -1, -1,  3, -1, 65, 1'b1);
        dump_a("reset15", 15, -1, -1, -1, 15, 33, 1'b0);
        dump_a("after_reset", 32, -1, -1, -1, -1, 65, 1'b1);

        // Sub-range instance: registers 4..6 only.
        for (int i = 4; i <= 6; i++) qb.push_back(exp_beat(i));
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        chk("range_rf_ra_first", 64'(rf_ra_b), 64'd4);
        for (c = 1; c < 100; c++) begin
            if (done_b) break;
            @(posedge clk); #1;
        end
        chk("range_end_cycle", 64'(c), 64'd7);
        repeat (3) @(posedge clk);
        #1;
        chk("range_done_count", 64'(done_cnt_b), 64'd1);
        chk("range_queue_drained", 64'(qb.size()), 64'd0);
        chk("range_idle", 64'(busy_b), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_dumper.md
# regfile_dumper

Sequential read-out engine for the 32×32 three-port register file. On a start pulse it takes over one register-file read port and walks registers FIRST_REG..LAST_REG. Each word it reads is emitted as an {address, data} beat on a valid/ready stream toward the debug/trace path. While a dump is in progress it asserts cpu_stall, so no write-port traffic can alter the snapshot.

## Interface
Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- FIRST_REG, 0, first register index dumped
- LAST_REG, 31, last register index dumped; must satisfy FIRST_REG ≤ LAST_REG ≤ 2^ADDR_W−1

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a dump; ignored unless idle
- abort  in  1  terminate the current dump; ignored when idle
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- done  out  1  one-cycle pulse after the last beat is accepted; never asserted on abort
- cpu_stall  out  1  equal to busy; freezes the pipeline and register-file writes
- rf_ra  out  ADDR_W  read address driven into a register-file read port
- rf_rd  in  DATA_W  combinational read data from that port
- dump_valid  out  1  beat valid
- dump_ready  in  1  consumer accepts the beat
- dump_addr  out  ADDR_W  register index of the current beat
- dump_data  out  DATA_W  register contents of the current beat

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: on start, load addr ← FIRST_REG and go to READ.
- READ:
  - Drive rf_ra = addr.
  - Latch dump_data ← rf_rd and dump_addr ← addr at the clock edge.
  - Go to SEND.
- SEND:
  - dump_valid = 1.
  - dump_addr and dump_data stay stable until the handshake (dump_valid && dump_ready).
  - On handshake: if addr == LAST_REG, go to DONE; otherwise addr ← addr+1 and go to READ.
  - Without a handshake, remain in SEND.
- DONE: done = 1 for this cycle only, then go to IDLE.
- Abort:
  - In READ or SEND, abort forces IDLE on the next edge. No further beats are issued and done is not asserted.
  - If abort and a handshake coincide in SEND, the beat counts as delivered, but abort still wins and no more beats follow.
  - Abort in DONE has no effect; done still pulses.
- Register 0 dumps as 0, because the register file hardwires it.
- A start while busy is ignored; it is not queued.
- rf_ra holds the last driven address when not in READ. The value is don't-care outside READ but must be known (not X).
- Address arithmetic is ADDR_W bits. addr never increments past LAST_REG, so no wrap-around occurs.

## Timing
- Reset values: state=IDLE, busy=0, cpu_stall=0, done=0, dump_valid=0, dump_addr=0, dump_data=0, rf_ra=0, addr=0.
- Reset mid-dump takes effect on the next edge, with the same result as an abort. dump_valid may drop without a handshake.
- Start latency: start at edge N means READ during cycle N+1 and dump_valid high during cycle N+2.
- Throughput: one beat per 2 cycles with dump_ready held high.
- Full dump (32 registers, ready always high): 64 busy cycles, then done. busy deasserts in the same cycle that done pulses.
- The read is combinational: rf_rd is sampled at the end of the READ cycle, so no extra latency cycle is needed.
- dump_valid never depends combinationally on dump_ready.
- cpu_stall must be high by the first READ cycle. Writes issued in the same cycle as start are allowed to land before READ of that register.

## Structure
- Shared defines header:
  - state encodings (IDLE=2'd0, READ=2'd1, SEND=2'd2, DONE=2'd3)
  - default ADDR_W/DATA_W, shared with the register file
- Single module, no sub-module: one state register, one address counter, output data/addr registers.
- The integration test wrapper instantiates regfile beside regfile_dumper. rf_ra is muxed onto read port 1 when busy.

## Test plan
- Preload r1..r31 = 32'h1000_0000+i; pulse start with dump_ready=1 → 32 beats: addr 0 data 0, then addr i data 32'h1000_0000+i; done pulses once, 64 cycles after start.
- dump_ready held low 5 cycles on beat addr 7 → valid, addr 7 and data stay stable for all 5 cycles; the next beat is addr 8.
- FIRST_REG=4, LAST_REG=6 → exactly 3 beats (addr 4, 5, 6), then done.
- abort asserted in SEND for addr 10 with ready=0 → IDLE next cycle, dump_valid=0, busy=0, no done, no beat for addr 10.
- start pulsed again at addr 3 mid-dump → ignored; the sequence continues to 31 with a single done.
- reset asserted mid-dump (addr 15), then released and start pulsed → all outputs at reset values; the new dump restarts at addr 0.
